// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants and types for the HUB75 receive path.
// Pixel words are packed {B1,G1,R1,B0,G0,R0}, matching the panel pin order.
package hub75_pkg;

    // Default panel geometry: one 32-column chain, rows addressed by A-D.
    localparam int PANEL_WIDTH     = 32;
    localparam int PANEL_ADDR_BITS = 4;

    // Bit positions of each colour line inside a pixel word.
    localparam int RGB_R0 = 0;
    localparam int RGB_G0 = 1;
    localparam int RGB_B0 = 2;
    localparam int RGB_R1 = 3;
    localparam int RGB_G1 = 4;
    localparam int RGB_B1 = 5;

    // One column's worth of data: upper and lower half-panel RGB.
    typedef logic [5:0] pix_t;

    // Assemble a pixel word from its six colour bits.
    function automatic pix_t pix_make(input logic r0, input logic g0, input logic b0,
                                      input logic r1, input logic g1, input logic b1);
        pix_t p;
        p         = '0;
        p[RGB_R0] = r0;
        p[RGB_G0] = g0;
        p[RGB_B0] = b0;
        p[RGB_R1] = r1;
        p[RGB_G1] = g1;
        p[RGB_B1] = b1;
        return p;
    endfunction

endpackage

// File: rtl/hub75_rx_edge.sv
// hub75_rx_edge: input sampling and rising-edge detection for the HUB75 pins.
// Macro HUB75_RX_SYNC_EN adds a two-flop synchronizer ahead of the input
// register (latency 3); without it a single input register is used (latency 1).
// clk_rise/stb_rise are registered alongside the sampled rgb/addr/oe, so a
// rise pulse and the data word it qualifies come out of the same sample.
module hub75_rx_edge
    import hub75_pkg::*;
#(
    parameter int ADDR_BITS = PANEL_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           pin_rgb,
    input  logic [ADDR_BITS-1:0] pin_addr,
    input  logic                 pin_clk,
    input  logic                 pin_stb,
    input  logic                 pin_oe,
    output pix_t                 rgb,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 oe,
    output logic                 clk_rise,
    output logic                 stb_rise
);

    // Data bundle carried in lockstep: {oe, addr, rgb}.
    localparam int DW = 6 + ADDR_BITS + 1;

    logic [DW-1:0] data_d;
    logic          clk_d;
    logic          stb_d;

`ifdef HUB75_RX_SYNC_EN
    logic [DW-1:0] data_s1_reg;
    logic [DW-1:0] data_s2_reg;
    logic          clk_s1_reg;
    logic          clk_s2_reg;
    logic          stb_s1_reg;
    logic          stb_s2_reg;

    // Two-flop synchronizer. The clk/stb flops reset high because they form
    // part of the edge history: a pin held high across reset must not look
    // like a fresh 0->1 transition once the chain refills.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s1_reg <= '0;
            data_s2_reg <= '0;
            clk_s1_reg  <= 1'b1;
            clk_s2_reg  <= 1'b1;
            stb_s1_reg  <= 1'b1;
            stb_s2_reg  <= 1'b1;
        end else begin
            data_s1_reg <= {pin_oe, pin_addr, pin_rgb};
            data_s2_reg <= data_s1_reg;
            clk_s1_reg  <= pin_clk;
            clk_s2_reg  <= clk_s1_reg;
            stb_s1_reg  <= pin_stb;
            stb_s2_reg  <= stb_s1_reg;
        end
    end

    assign data_d = data_s2_reg;
    assign clk_d  = clk_s2_reg;
    assign stb_d  = stb_s2_reg;
`else
    assign data_d = {pin_oe, pin_addr, pin_rgb};
    assign clk_d  = pin_clk;
    assign stb_d  = pin_stb;
`endif

    logic [DW-1:0] data_reg;
    logic          clk_prev_reg;
    logic          stb_prev_reg;
    logic          clk_rise_reg;
    logic          stb_rise_reg;

    // Input register plus edge detect. Previous values reset to 1 so a line
    // already high when reset releases produces no edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= '0;
            clk_prev_reg <= 1'b1;
            stb_prev_reg <= 1'b1;
            clk_rise_reg <= 1'b0;
            stb_rise_reg <= 1'b0;
        end else begin
            data_reg     <= data_d;
            clk_prev_reg <= clk_d;
            stb_prev_reg <= stb_d;
            clk_rise_reg <= clk_d & ~clk_prev_reg;
            stb_rise_reg <= stb_d & ~stb_prev_reg;
        end
    end

    assign rgb      = data_reg[5:0];
    assign addr     = data_reg[6 +: ADDR_BITS];
    assign oe       = data_reg[DW-1];
    assign clk_rise = clk_rise_reg;
    assign stb_rise = stb_rise_reg;

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 receiver. Rebuilds one panel chain's shift register and
// row latch from the sampled pins and exposes the latched row on a registered
// column read port, with line-length and frame-wrap status per latch.
// Macro HUB75_RX_SYNC_EN (in hub75_rx_edge) selects synchronized input sampling.
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int WIDTH     = PANEL_WIDTH,
    parameter int ADDR_BITS = PANEL_ADDR_BITS,
    parameter int CNT_BITS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               pin_rgb,
    input  logic [ADDR_BITS-1:0]     pin_addr,
    input  logic                     pin_clk,
    input  logic                     pin_stb,
    input  logic                     pin_oe,
    output logic                     line_valid,
    output logic [ADDR_BITS-1:0]     line_addr,
    output logic                     line_short,
    output logic                     line_long,
    output logic                     frame_start,
    output logic                     oe_seen,
    input  logic [$clog2(WIDTH)-1:0] rd_col,
    output logic [5:0]               rd_pix
);

    localparam int                  COL_BITS  = $clog2(WIDTH);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;
    localparam logic [CNT_BITS-1:0] WIDTH_CNT = CNT_BITS'(WIDTH);
    localparam logic [COL_BITS:0]   WIDTH_COL = (COL_BITS + 1)'(WIDTH);

    pix_t                 s_rgb;
    logic [ADDR_BITS-1:0] s_addr;
    logic                 s_oe;
    logic                 clk_rise;
    logic                 stb_rise;

    hub75_rx_edge #(
        .ADDR_BITS (ADDR_BITS)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .pin_rgb  (pin_rgb),
        .pin_addr (pin_addr),
        .pin_clk  (pin_clk),
        .pin_stb  (pin_stb),
        .pin_oe   (pin_oe),
        .rgb      (s_rgb),
        .addr     (s_addr),
        .oe       (s_oe),
        .clk_rise (clk_rise),
        .stb_rise (stb_rise)
    );

    // Shift buffer and row latch, one pixel word per column.
    pix_t shift_reg  [WIDTH];
    pix_t shift_next [WIDTH];
    pix_t latch_reg  [WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_col
            // Next shift value: words move toward column 0, new word enters at the top.
            if (gi == WIDTH - 1) begin : g_top
                assign shift_next[gi] = clk_rise ? s_rgb : shift_reg[gi];
            end else begin : g_mid
                assign shift_next[gi] = clk_rise ? shift_reg[gi+1] : shift_reg[gi];
            end

            // Shift on CLK; latch the post-shift view on STB so a coincident
            // CLK edge's word is included in the latched row.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_reg[gi] <= '0;
                    latch_reg[gi] <= '0;
                end else begin
                    shift_reg[gi] <= shift_next[gi];
                    if (stb_rise) begin
                        latch_reg[gi] <= shift_next[gi];
                    end
                end
            end
        end
    endgenerate

    // Saturating count of CLK edges since the last latch, including this cycle's edge.
    logic [CNT_BITS-1:0] bit_cnt_reg;
    logic [CNT_BITS-1:0] bit_cnt_next;

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (clk_rise && (bit_cnt_reg != CNT_MAX)) begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
        end
    end

    logic                 line_valid_reg;
    logic [ADDR_BITS-1:0] line_addr_reg;
    logic                 line_short_reg;
    logic                 line_long_reg;
    logic                 frame_start_reg;
    logic [ADDR_BITS-1:0] prev_addr_reg;

    // Latch bookkeeping: status flags, captured address and frame-wrap detect.
    // prev_addr resets to all-ones so the first latch after reset always wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg     <= '0;
            line_valid_reg  <= 1'b0;
            line_addr_reg   <= '0;
            line_short_reg  <= 1'b0;
            line_long_reg   <= 1'b0;
            frame_start_reg <= 1'b0;
            prev_addr_reg   <= '1;
        end else begin
            line_valid_reg  <= stb_rise;
            frame_start_reg <= stb_rise && (s_addr <= prev_addr_reg);
            if (stb_rise) begin
                bit_cnt_reg    <= '0;
                line_addr_reg  <= s_addr;
                line_short_reg <= (bit_cnt_next < WIDTH_CNT);
                line_long_reg  <= (bit_cnt_next > WIDTH_CNT);
                prev_addr_reg  <= s_addr;
            end else begin
                bit_cnt_reg <= bit_cnt_next;
            end
        end
    end

    pix_t rd_pix_reg;

    // Registered column read; out-of-range columns read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pix_reg <= '0;
        end else if ({1'b0, rd_col} < WIDTH_COL) begin
            rd_pix_reg <= latch_reg[rd_col];
        end else begin
            rd_pix_reg <= '0;
        end
    end

    assign line_valid  = line_valid_reg;
    assign line_addr   = line_addr_reg;
    assign line_short  = line_short_reg;
    assign line_long   = line_long_reg;
    assign frame_start = frame_start_reg;
    assign oe_seen     = s_oe;
    assign rd_pix      = rd_pix_reg;

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: directed test of hub75_rx with hand-computed expectations.
module tb_hub75_rx;

`ifdef HUB75_RX_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif
    // Pin high/low hold time in clk cycles.
    localparam int HOLD = (L > 1) ? (L + 1) : 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pin_rgb = '0;
    logic [3:0] pin_addr = '0;
    logic       pin_clk = 1'b0;
    logic       pin_stb = 1'b0;
    logic       pin_oe = 1'b0;
    logic       line_valid;
    logic [3:0] line_addr;
    logic       line_short;
    logic       line_long;
    logic       frame_start;
    logic       oe_seen;
    logic [4:0] rd_col = '0;
    logic [5:0] rd_pix;

    int n_checks = 0;
    int n_fail   = 0;
    int lv_cnt   = 0;
    int fs_cnt   = 0;

    hub75_rx #(
        .WIDTH     (32),
        .ADDR_BITS (4),
        .CNT_BITS  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pin_rgb     (pin_rgb),
        .pin_addr    (pin_addr),
        .pin_clk     (pin_clk),
        .pin_stb     (pin_stb),
        .pin_oe      (pin_oe),
        .line_valid  (line_valid),
        .line_addr   (line_addr),
        .line_short  (line_short),
        .line_long   (line_long),
        .frame_start (frame_start),
        .oe_seen     (oe_seen),
        .rd_col      (rd_col),
        .rd_pix      (rd_pix)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (line_valid)  lv_cnt++;
        if (frame_start) fs_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clk_word(input logic [5:0] w);
        pin_rgb = w;
        pin_clk = 1'b0;
        repeat (HOLD) tick();
        pin_clk = 1'b1;
        repeat (HOLD) tick();
    endtask

    task automatic strobe(input logic [3:0] a);
        pin_addr = a;
        pin_stb  = 1'b1;
        repeat (HOLD) tick();
        pin_stb = 1'b0;
        repeat (HOLD + L + 2) tick();
    endtask

    task automatic read_pix(input logic [4:0] col, output int val);
        rd_col = col;
        tick();
        val = int'(rd_pix);
    endtask

    // Strobe and check the count of line_valid / frame_start pulses it produced.
    task automatic strobe_chk(input string tag, input logic [3:0] a, input int exp_fs);
        int lv0, fs0;
        lv0 = lv_cnt;
        fs0 = fs_cnt;
        strobe(a);
        check({tag, "_lv_pulses"}, lv_cnt - lv0, 1);
        check({tag, "_fs_pulses"}, fs_cnt - fs0, exp_fs);
        check({tag, "_addr"}, int'(line_addr), int'(a));
    endtask

    task automatic pix_chk(input string tag, input logic [4:0] col, input int exp);
        int v;
        read_pix(col, v);
        check($sformatf("%s_col%0d", tag, col), v, exp);
    endtask

    initial begin
        int lv0;

        // Reset with pin_clk high and data on the bus: nothing may shift in.
        rst = 1'b1; pin_clk = 1'b1; pin_rgb = 6'h2A; pin_oe = 1'b1;
        repeat (4) tick();
        check("rst_line_valid", int'(line_valid), 0);
        check("rst_line_addr", int'(line_addr), 0);
        check("rst_line_short", int'(line_short), 0);
        check("rst_line_long", int'(line_long), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_oe_seen", int'(oe_seen), 0);
        check("rst_rd_pix", int'(rd_pix), 0);
        rst = 1'b0;
        repeat (L + 1) tick();
        check("oe_seen_high", int'(oe_seen), 1);
        pin_oe = 1'b0;
        repeat (L) tick();
        check("oe_seen_low_latency", int'(oe_seen), 0);

        strobe_chk("clkhigh", 4'd3, 1);
        check("clkhigh_short", int'(line_short), 1);
        check("clkhigh_long", int'(line_long), 0);
        pix_chk("clkhigh", 5'd31, 0);
        pix_chk("clkhigh", 5'd0, 0);

        // Full line: word = column index.
        for (int i = 0; i < 32; i++) clk_word(6'(i));
        strobe_chk("full", 4'd5, 0);
        check("full_short", int'(line_short), 0);
        check("full_long", int'(line_long), 0);
        pix_chk("full", 5'd0, 0);
        pix_chk("full", 5'd17, 17);
        pix_chk("full", 5'd31, 31);

        // Short line: 30 new words on top of the previous 0..31.
        for (int i = 0; i < 30; i++) clk_word(6'(i + 40));
        strobe_chk("short", 4'd6, 0);
        check("short_short", int'(line_short), 1);
        check("short_long", int'(line_long), 0);
        pix_chk("short", 5'd0, 30);
        pix_chk("short", 5'd1, 31);
        pix_chk("short", 5'd2, 40);
        pix_chk("short", 5'd31, 5);

        // Long line: 34 words, first two fall off column 0.
        for (int i = 0; i < 34; i++) clk_word(6'(i + 10));
        strobe_chk("long", 4'd7, 0);
        check("long_short", int'(line_short), 0);
        check("long_long", int'(line_long), 1);
        pix_chk("long", 5'd0, 12);
        pix_chk("long", 5'd31, 43);

        // 31 edges, then CLK and STB rise in the same sample cycle.
        for (int i = 0; i < 31; i++) clk_word(6'(i + 20));
        lv0 = lv_cnt;
        pin_rgb = 6'd55; pin_clk = 1'b0;
        repeat (HOLD) tick();
        pin_clk = 1'b1; pin_stb = 1'b1; pin_addr = 4'd8;
        repeat (HOLD) tick();
        pin_stb = 1'b0;
        repeat (HOLD + L + 2) tick();
        check("simul_lv_pulses", lv_cnt - lv0, 1);
        check("simul_addr", int'(line_addr), 8);
        check("simul_short", int'(line_short), 0);
        check("simul_long", int'(line_long), 0);
        pix_chk("simul", 5'd0, 20);
        pix_chk("simul", 5'd30, 50);
        pix_chk("simul", 5'd31, 55);

        // 288 edges: a wrapping counter would read 32 and miss line_long.
        for (int i = 0; i < 288; i++) clk_word(6'((i + 3) & 63));
        strobe_chk("sat", 4'd9, 0);
        check("sat_short", int'(line_short), 0);
        check("sat_long", int'(line_long), 1);
        pix_chk("sat", 5'd0, 3);
        pix_chk("sat", 5'd31, 34);

        // Reset mid-line discards the partial line.
        for (int i = 0; i < 16; i++) clk_word(6'(i + 1));
        lv0 = lv_cnt;
        rst = 1'b1;
        repeat (3) tick();
        check("midrst_long_cleared", int'(line_long), 0);
        check("midrst_rd_pix", int'(rd_pix), 0);
        rst = 1'b0;
        repeat (2) tick();
        check("midrst_no_lv", lv_cnt - lv0, 0);
        strobe_chk("midrst", 4'd2, 1);
        check("midrst_short", int'(line_short), 1);
        check("midrst_long", int'(line_long), 0);
        pix_chk("midrst", 5'd0, 0);
        pix_chk("midrst", 5'd15, 0);
        pix_chk("midrst", 5'd31, 0);

        // Frame wrap: rows 0..15 then 0 after a fresh reset.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        for (int r = 0; r < 17; r++) begin
            strobe_chk($sformatf("row%0d", r), 4'(r & 15), (r == 0 || r == 16) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
